// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, SPI mode encodings and a clog2 helper for the SPI transmitter.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} spi_state_t;

    // {CPOL,CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator; tick fires on the CLK_DIV-th enabled cycle and the count wraps.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2000
) (
    input  logic RST_clk,
    input  logic RST_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge RST_clk or negedge RST_n)
        if (!RST_n) cnt <= '0;
        else        cnt <= (!enable || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: parametrised SPI master transmitter with valid/ready input and active-low chip select.
// Define SPI_TX_MISO_EN to add MISO capture (spi_rx_data, rx_data, rx_valid).
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2000,
    parameter int GAP_CYC   = 20,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              RST_clk,
    input  logic              RST_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              spi_clk,
    output logic              spi_tx_data,
    output logic              spi_cs_n,
    output logic              spi_busy
`ifdef SPI_TX_MISO_EN
    ,
    input  logic              spi_rx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
`endif
);

    localparam int BW = clog2(DATA_W) + 1;
    localparam int GW = clog2(GAP_CYC) + 1;
    localparam logic [BW-1:0] NBITS = BW'(DATA_W);

    spi_state_t state, state_n;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [DATA_W-1:0] tx_sr, tx_sr_n;
    logic tick, div_en, accept, lead_edge, sample_edge, shift_edge, last_edge;

    assign div_en    = (state == LEAD) || (state == SHIFT) || (state == TRAIL);
    assign tx_ready  = (state == IDLE);
    assign accept    = tx_valid && tx_ready;
    assign lead_edge = (spi_clk == CPOL);
    assign tx_sr_n   = MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .RST_clk (RST_clk),
        .RST_n   (RST_n),
        .enable  (div_en),
        .tick    (tick)
    );

    // The first bit is already on MOSI from LEAD, so the shift edge that would re-present it is skipped.
    always_comb begin
        sample_edge = tick && (state == SHIFT) && (lead_edge != CPHA);
        shift_edge  = tick && (state == SHIFT) && (lead_edge == CPHA) &&
                      (CPHA ? (bit_cnt != '0) : (bit_cnt != NBITS));
        last_edge   = tick && (state == SHIFT) && !lead_edge &&
                      (bit_cnt == (CPHA ? NBITS - 1'b1 : NBITS));
        state_n     = (state == IDLE && accept)                    ? LEAD  :
                      (state == LEAD && tick)                      ? SHIFT :
                      last_edge                                    ? TRAIL :
                      (state == TRAIL && tick)                     ? GAP   :
                      (state == GAP && gap_cnt == GW'(GAP_CYC - 1)) ? IDLE  : state;
    end

    always_ff @(posedge RST_clk or negedge RST_n)
        if (!RST_n) state <= IDLE;
        else        state <= state_n;

    always_ff @(posedge RST_clk or negedge RST_n)
        if (!RST_n) begin
            spi_clk     <= CPOL;
            spi_tx_data <= 1'b1;
            spi_cs_n    <= 1'b1;
            spi_busy    <= 1'b0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            tx_sr       <= '0;
        end else begin
            if (accept) begin
                tx_sr       <= tx_data;
                spi_tx_data <= MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
                spi_cs_n    <= 1'b0;
                spi_busy    <= 1'b1;
                bit_cnt     <= '0;
            end
            if (tick && state == SHIFT) spi_clk <= ~spi_clk;
            if (sample_edge) bit_cnt <= bit_cnt + 1'b1;
            if (shift_edge) begin
                tx_sr       <= tx_sr_n;
                spi_tx_data <= MSB_FIRST ? tx_sr_n[DATA_W-1] : tx_sr_n[0];
            end
            if (last_edge) spi_tx_data <= 1'b1;
            if (tick && state == TRAIL) spi_cs_n <= 1'b1;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (state == GAP && state_n == IDLE) spi_busy <= 1'b0;
        end

`ifdef SPI_TX_MISO_EN
    logic [DATA_W-1:0] rx_sr, rx_sr_n;

    assign rx_sr_n = MSB_FIRST ? {rx_sr[DATA_W-2:0], spi_rx_data} : {spi_rx_data, rx_sr[DATA_W-1:1]};

    // With CPHA=1 the last sample coincides with the final edge, so it is folded in directly.
    always_ff @(posedge RST_clk or negedge RST_n)
        if (!RST_n) begin
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (sample_edge) rx_sr <= rx_sr_n;
            rx_valid <= last_edge;
            if (last_edge) rx_data <= sample_edge ? rx_sr_n : rx_sr;
        end
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed checks of spi_master_tx in modes 0/3, LSB-first, back-to-back and mid-frame reset.
module tb_spi_master_tx;

    logic clk = 1'b0;
    logic RST_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  tx0, tx3;
    logic [11:0] txl;
    logic tv0 = 0, tv3 = 0, tvl = 0;
    logic rdy0, sclk0, mosi0, cs0, busy0;
    logic rdy3, sclk3, mosi3, cs3, busy3;
    logic rdyl, sclkl, mosil, csl, busyl;
`ifdef SPI_TX_MISO_EN
    logic [7:0]  rxd0, rxd3;
    logic [11:0] rxdl;
    logic rxv0, rxv3, rxvl;
    int unsigned rxv_cnt = 0;
    logic [7:0] rx_last = '0;
    always @(negedge clk) if (rxv0) begin
        rxv_cnt <= rxv_cnt + 1;
        rx_last <= rxd0;
    end
`endif

    spi_master_tx #(.DATA_W(8), .CLK_DIV(2), .GAP_CYC(3), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
        .RST_clk(clk), .RST_n(RST_n), .tx_data(tx0), .tx_valid(tv0), .tx_ready(rdy0),
        .spi_clk(sclk0), .spi_tx_data(mosi0), .spi_cs_n(cs0), .spi_busy(busy0)
`ifdef SPI_TX_MISO_EN
        , .spi_rx_data(mosi0), .rx_data(rxd0), .rx_valid(rxv0)
`endif
    );

    spi_master_tx #(.DATA_W(8), .CLK_DIV(2), .GAP_CYC(3), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u3 (
        .RST_clk(clk), .RST_n(RST_n), .tx_data(tx3), .tx_valid(tv3), .tx_ready(rdy3),
        .spi_clk(sclk3), .spi_tx_data(mosi3), .spi_cs_n(cs3), .spi_busy(busy3)
`ifdef SPI_TX_MISO_EN
        , .spi_rx_data(1'b0), .rx_data(rxd3), .rx_valid(rxv3)
`endif
    );

    spi_master_tx #(.DATA_W(12), .CLK_DIV(2), .GAP_CYC(3), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) ul (
        .RST_clk(clk), .RST_n(RST_n), .tx_data(txl), .tx_valid(tvl), .tx_ready(rdyl),
        .spi_clk(sclkl), .spi_tx_data(mosil), .spi_cs_n(csl), .spi_busy(busyl)
`ifdef SPI_TX_MISO_EN
        , .spi_rx_data(1'b0), .rx_data(rxdl), .rx_valid(rxvl)
`endif
    );

    int sel = 0;
    logic m_clk, m_mosi, m_cs, m_rdy;
    always_comb begin
        m_clk = sclk0; m_mosi = mosi0; m_cs = cs0; m_rdy = rdy0;
        if (sel == 1) begin m_clk = sclk3; m_mosi = mosi3; m_cs = cs3; m_rdy = rdy3; end
        if (sel == 2) begin m_clk = sclkl; m_mosi = mosil; m_cs = csl; m_rdy = rdyl; end
    end

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tx(input int s, input logic [31:0] w, input logic v);
        if (s == 0) begin tx0 = w[7:0]; tv0 = v; end
        else if (s == 1) begin tx3 = w[7:0]; tv3 = v; end
        else begin txl = w[11:0]; tvl = v; end
    endtask

    // Bits are recorded from the MOSI value held just before each SCLK rising edge.
    task automatic run_frame(input int s, input logic [31:0] w,
                             output logic [31:0] got, output int low, output int rises);
        logic pclk, pmosi;
        int n;
        sel = s; got = '0; low = 0; rises = 0; n = 0;
        @(negedge clk);
        while (!m_rdy && n < 500) begin @(negedge clk); n++; end
        set_tx(s, w, 1'b1);
        pclk = m_clk; pmosi = m_mosi; n = 0;
        do begin
            @(negedge clk);
            set_tx(s, w, 1'b0);
            if (!m_cs) low++;
            if (m_clk && !pclk) begin rises++; got = {got[30:0], pmosi}; end
            pclk = m_clk; pmosi = m_mosi; n++;
        end while ((!m_cs || low == 0) && n < 500);
    endtask

    logic [31:0] got;
    int low, rises, phase, hi, blo, bad;

    initial begin
        tx0 = '0; tx3 = '0; txl = '0;
        #1 RST_n = 1'b0;
        #11;
        check("rst_cs", cs0, 1);
        check("rst_clk0", sclk0, 0);
        check("rst_clk3", sclk3, 1);
        check("rst_mosi", mosi0, 1);
        check("rst_busy", busy0, 0);
        check("rst_ready", rdy0, 1);
        @(negedge clk); RST_n = 1'b1;

        run_frame(0, 32'hA5, got, low, rises);
        check("m0_data", got, 32'hA5);
        check("m0_cs_low", low, 36);
        check("m0_rises", rises, 8);

        check("m3_idle_clk", sclk3, 1);
        run_frame(1, 32'hA5, got, low, rises);
        check("m3_data", got, 32'hA5);
        check("m3_cs_low", low, 36);
        check("m3_rises", rises, 8);
        check("m3_clk_after", sclk3, 1);

        run_frame(2, 32'h801, got, low, rises);
        check("lsb_801", got, 32'h801);
        check("lsb_cs_low", low, 52);
        check("lsb_rises", rises, 12);
        run_frame(2, 32'h0F3, got, low, rises);
        check("lsb_0f3", got, 32'hCF0);

        // Back-to-back: hold tx_valid and measure the inter-frame gap.
        repeat (10) @(negedge clk);
        tx0 = 8'hC3; tv0 = 1'b1;
        phase = 0; hi = 0; blo = 0; bad = 0;
        for (int i = 0; i < 300 && phase < 3; i++) begin
            @(negedge clk);
            if (rdy0 == busy0) bad++;
            if (phase == 0 && !cs0) phase = 1;
            else if (phase == 1 && cs0) phase = 2;
            else if (phase == 2 && !cs0) phase = 3;
            if (phase == 2) begin hi++; if (!busy0) blo++; end
        end
        tv0 = 1'b0;
        check("b2b_second_frame", phase, 3);
        check("b2b_cs_high", hi, 4);
        check("b2b_busy_low", blo, 1);
        check("b2b_ready_vs_busy", bad, 0);

        // Reset during the 4th bit (bit 4 of 0xC3 = 0), between clock edges.
        repeat (16) @(negedge clk);
        check("mid_cs", cs0, 0);
        check("mid_clk", sclk0, 1);
        check("mid_mosi", mosi0, 0);
        #2 RST_n = 1'b0;
        #1;
        check("arst_cs", cs0, 1);
        check("arst_clk", sclk0, 0);
        check("arst_mosi", mosi0, 1);
        check("arst_busy", busy0, 0);
        check("arst_ready", rdy0, 1);
        @(negedge clk); RST_n = 1'b1;
        run_frame(0, 32'h5A, got, low, rises);
        check("post_rst_data", got, 32'h5A);
        check("post_rst_cs_low", low, 36);
        check("post_rst_rises", rises, 8);

`ifdef SPI_TX_MISO_EN
        begin
            int unsigned base;
            repeat (10) @(negedge clk);
            base = rxv_cnt;
            run_frame(0, 32'h3C, got, low, rises);
            repeat (5) @(negedge clk);
            check("rx_pulses", rxv_cnt - base, 1);
            check("rx_data", rx_last, 32'h3C);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
